// File: rtl/uart_pulse_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pulse_cmd_parser
//  Brief    : Assembles 8-byte UART command frames, validates them, latches the
//             pulse parameters, fires functionGenerate and replies ack/nack.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_pulse_cmd_parser #(
  parameter logic [7:0] HEADER      = 8'h07,
  parameter logic [7:0] CMD_FIRE    = 8'h01,
  parameter logic [7:0] CMD_CFG     = 8'h00,
  parameter logic [7:0] ACK_BYTE    = 8'hA5,
  parameter logic [7:0] NACK_BYTE   = 8'hEE,
  parameter int         TIMEOUT_CYC = 104_166
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] po_data,
  input  logic       po_flag,
  output logic [6:0] pulse_width1,
  output logic [6:0] pulse_width2,
  output logic [6:0] pulse_gap,
  output logic       fire,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] tx_data,
  output logic       tx_flag
);

  localparam int               c_TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_TW-1:0]  c_TO = c_TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t          r_state;
  logic [2:0]      r_idx;
  logic [c_TW-1:0] r_timer;
  logic [7:0]      r_buf [8];

  logic [7:0]      w_xor;
  logic            w_cmd_ok;
  logic            w_range_bad;
  logic            w_hdr;

  always_comb begin
    w_xor = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w_xor = w_xor ^ r_buf[i];
    end
  end

  assign w_cmd_ok    = (r_buf[1] == CMD_FIRE) || (r_buf[1] == CMD_CFG);
  assign w_range_bad = r_buf[3][7] | r_buf[4][7] | r_buf[5][7];
  assign w_hdr       = po_flag && (po_data == HEADER);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= S_IDLE;
      r_idx        <= 3'd0;
      r_timer      <= '0;
      for (int i = 0; i < 8; i++) begin
        r_buf[i] <= 8'h00;
      end
      pulse_width1 <= 7'd0;
      pulse_width2 <= 7'd0;
      pulse_gap    <= 7'd0;
      fire         <= 1'b0;
      frame_ok     <= 1'b0;
      frame_err    <= 1'b0;
      err_code     <= 2'b00;
      tx_data      <= 8'h00;
      tx_flag      <= 1'b0;
    end else begin
      fire      <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      tx_flag   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_hdr) begin
            r_buf[0] <= po_data;
            r_idx    <= 3'd1;
            r_timer  <= '0;
            r_state  <= S_RECV;
          end
        end
        S_RECV: begin
          // The timeout takes precedence over a byte arriving in the same cycle.
          if (r_timer == c_TO) begin
            frame_err <= 1'b1;
            err_code  <= 2'b01;
            r_idx     <= 3'd0;
            r_timer   <= '0;
            r_state   <= S_IDLE;
          end else if (po_flag) begin
            r_buf[r_idx] <= po_data;
            r_timer      <= '0;
            if (r_idx == 3'd7) begin
              r_idx   <= 3'd0;
              r_state <= S_CHECK;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_timer <= r_timer + c_TW'(1);
          end
        end
        S_CHECK: begin
          tx_flag <= 1'b1;
          if (w_xor != 8'h00) begin
            frame_err <= 1'b1;
            err_code  <= 2'b10;
            tx_data   <= NACK_BYTE;
          end else if (!w_cmd_ok || w_range_bad) begin
            frame_err <= 1'b1;
            err_code  <= 2'b11;
            tx_data   <= NACK_BYTE;
          end else begin
            pulse_width1 <= r_buf[3][6:0];
            pulse_width2 <= r_buf[4][6:0];
            pulse_gap    <= r_buf[5][6:0];
            frame_ok     <= 1'b1;
            fire         <= (r_buf[1] == CMD_FIRE);
            err_code     <= 2'b00;
            tx_data      <= ACK_BYTE;
          end
          // A header arriving while the previous frame is judged opens the next frame.
          if (w_hdr) begin
            r_buf[0] <= po_data;
            r_idx    <= 3'd1;
            r_timer  <= '0;
            r_state  <= S_RECV;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_pulse_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_pulse_cmd_parser
//  Brief    : Randomized self-checking bench for uart_pulse_cmd_parser.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_pulse_cmd_parser;

  localparam int TO = 200;

  typedef logic [7:0][7:0] frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] po_data = 8'h00;
  logic       po_flag = 1'b0;
  logic [6:0] pulse_width1, pulse_width2, pulse_gap;
  logic       fire, frame_ok, frame_err, tx_flag;
  logic [1:0] err_code;
  logic [7:0] tx_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_ok = 0, cnt_err = 0, cnt_tx = 0, cnt_fire = 0;
  logic prev_tx = 1'b0;

  logic [6:0] exp_w1 = 7'd0, exp_w2 = 7'd0, exp_gap = 7'd0;

  uart_pulse_cmd_parser #(.TIMEOUT_CYC(TO)) dut (
    .sys_clk(clk), .sys_rst(rst), .po_data(po_data), .po_flag(po_flag),
    .pulse_width1(pulse_width1), .pulse_width2(pulse_width2), .pulse_gap(pulse_gap),
    .fire(fire), .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
    .tx_data(tx_data), .tx_flag(tx_flag)
  );

  always #5 clk = ~clk;

  // Strobe counters and cycle-level invariants.
  always begin
    @(posedge clk); #1;
    if (frame_ok)  cnt_ok++;
    if (frame_err) cnt_err++;
    if (fire)      cnt_fire++;
    if (tx_flag) begin
      cnt_tx++;
      n_checks++;
      if (prev_tx) begin
        n_fail++;
        $display("FAIL tx_flag_twice: tx_flag high in consecutive cycles, required single-cycle");
      end
    end
    if (fire) begin
      n_checks++;
      if (!frame_ok) begin
        n_fail++;
        $display("FAIL fire_without_ok: fire=1 frame_ok=%0b, required frame_ok=1", frame_ok);
      end
    end
    prev_tx = tx_flag;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic frame_t mk(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
    frame_t f;
    f[0] = b0; f[1] = b1; f[2] = b2; f[3] = b3;
    f[4] = b4; f[5] = b5; f[6] = b6; f[7] = b7;
    return f;
  endfunction

  // 0 accept, 2 checksum error, 3 command/range error
  function automatic int ref_verdict(input frame_t f);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 8; i++) x = x ^ f[i];
    if (x != 8'h00) return 2;
    if (!(f[1] == 8'h01 || f[1] == 8'h00)) return 3;
    if (f[3] > 8'd127 || f[4] > 8'd127 || f[5] > 8'd127) return 3;
    return 0;
  endfunction

  function automatic frame_t make_valid(input logic [7:0] cmd, w1, w2, g);
    frame_t f = mk(8'h07, cmd, 8'($urandom), w1, w2, g, 8'($urandom), 8'h00);
    for (int i = 0; i < 7; i++) f[7] = f[7] ^ f[i];
    return f;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    int c = $urandom_range(0, 9);
    logic [7:0] cmd = (c < 4) ? 8'h01 : (c < 8) ? 8'h00 : 8'($urandom);
    f = make_valid(cmd, {1'b0, 7'($urandom)}, {1'b0, 7'($urandom)}, {1'b0, 7'($urandom)});
    if ($urandom_range(0, 7) == 0) f[3 + $urandom_range(0, 2)][7] = 1'b1;
    if ($urandom_range(0, 5) == 0) f[7] = f[7] ^ 8'($urandom_range(1, 255));
    return f;
  endfunction

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    po_data = b;
    po_flag = 1'b1;
    @(posedge clk); #1;
    po_flag = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input int maxgap);
    for (int i = 0; i < 8; i++) begin
      send_byte(f[i]);
      if (maxgap > 0 && i < 7) idle($urandom_range(0, maxgap));
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    n_checks++;
    if ({pulse_width1, pulse_width2, pulse_gap, fire, frame_ok, frame_err, err_code, tx_data, tx_flag} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: w1=%0d w2=%0d gap=%0d fire=%0b ok=%0b err=%0b code=%0d tx=%h txf=%0b, required all 0",
               pulse_width1, pulse_width2, pulse_gap, fire, frame_ok, frame_err, err_code, tx_data, tx_flag);
    end
    rst = 1'b0;
    exp_w1 = 0; exp_w2 = 0; exp_gap = 0;
    idle(2);
  endtask

  task automatic test_frames(input int n_random);
    frame_t f;
    int v;
    logic [7:0] exp_tx;
    for (int k = 0; k < 4 + n_random; k++) begin
      case (k)
        0: f = mk(8'h07, 8'h01, 8'h00, 8'h0A, 8'h14, 8'h05, 8'h00, 8'h1D);
        1: f = mk(8'h07, 8'h00, 8'h00, 8'h0A, 8'h14, 8'h05, 8'h00, 8'h1C);
        2: f = mk(8'h07, 8'h01, 8'h00, 8'h0A, 8'h14, 8'h05, 8'h00, 8'h1E);
        3: f = mk(8'h07, 8'h01, 8'h00, 8'h8A, 8'h14, 8'h05, 8'h00, 8'h9D);
        default: f = rand_frame();
      endcase
      v = ref_verdict(f);
      send_frame(f, 0);
      n_checks++;
      if (frame_ok !== 1'b0 || frame_err !== 1'b0 || tx_flag !== 1'b0) begin
        n_fail++;
        $display("FAIL early_strobe[%0d]: ok=%0b err=%0b txf=%0b one cycle after last byte, required 0",
                 k, frame_ok, frame_err, tx_flag);
      end
      @(posedge clk); #1;
      if (v == 0) begin
        exp_w1 = f[3][6:0]; exp_w2 = f[4][6:0]; exp_gap = f[5][6:0];
        exp_tx = 8'hA5;
      end else begin
        exp_tx = 8'hEE;
      end
      n_checks++;
      if ({frame_ok, frame_err, fire} !== {v == 0, v != 0, v == 0 && f[1] == 8'h01}) begin
        n_fail++;
        $display("FAIL strobes[%0d]: ok/err/fire=%b%b%b, required %b%b%b", k, frame_ok, frame_err, fire,
                 v == 0, v != 0, v == 0 && f[1] == 8'h01);
      end
      n_checks++;
      if (tx_flag !== 1'b1 || tx_data !== exp_tx) begin
        n_fail++;
        $display("FAIL reply[%0d]: txf=%0b tx=%h, required txf=1 tx=%h", k, tx_flag, tx_data, exp_tx);
      end
      n_checks++;
      if ({pulse_width1, pulse_width2, pulse_gap} !== {exp_w1, exp_w2, exp_gap}) begin
        n_fail++;
        $display("FAIL params[%0d]: %0d/%0d/%0d, required %0d/%0d/%0d", k, pulse_width1, pulse_width2,
                 pulse_gap, exp_w1, exp_w2, exp_gap);
      end
      n_checks++;
      if (err_code !== 2'(v)) begin
        n_fail++;
        $display("FAIL err_code[%0d]: %0d, required %0d", k, err_code, v);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({tx_flag, frame_ok, frame_err, fire} !== 4'b0000 || tx_data !== exp_tx) begin
        n_fail++;
        $display("FAIL strobe_len[%0d]: txf/ok/err/fire=%b%b%b%b tx=%h, required 0000 tx=%h", k,
                 tx_flag, frame_ok, frame_err, fire, tx_data, exp_tx);
      end
    end
  endtask

  task automatic test_garbage();
    int ok0 = cnt_ok, err0 = cnt_err, tx0 = cnt_tx;
    logic [7:0] g;
    send_byte(8'h55);
    send_byte(8'hAA);
    repeat ($urandom_range(1, 5)) begin
      g = 8'($urandom);
      if (g == 8'h07) g = 8'h08;
      send_byte(g);
    end
    send_frame(mk(8'h07, 8'h01, 8'h00, 8'h0A, 8'h14, 8'h05, 8'h00, 8'h1D), 0);
    idle(3);
    exp_w1 = 7'd10; exp_w2 = 7'd20; exp_gap = 7'd5;
    n_checks++;
    if (cnt_ok - ok0 != 1 || cnt_err - err0 != 0 || cnt_tx - tx0 != 1) begin
      n_fail++;
      $display("FAIL garbage_counts: ok=%0d err=%0d tx=%0d, required 1/0/1", cnt_ok - ok0, cnt_err - err0, cnt_tx - tx0);
    end
    n_checks++;
    if ({pulse_width1, pulse_width2, pulse_gap} !== {exp_w1, exp_w2, exp_gap}) begin
      n_fail++;
      $display("FAIL garbage_params: %0d/%0d/%0d, required 10/20/5", pulse_width1, pulse_width2, pulse_gap);
    end
  endtask

  task automatic test_timeout();
    int ok0 = cnt_ok, err0 = cnt_err, tx0 = cnt_tx;
    frame_t f;
    send_byte(8'h07); send_byte(8'h01); send_byte(8'h00);
    idle(TO + 10);
    n_checks++;
    if (cnt_err - err0 != 1 || cnt_ok != ok0 || cnt_tx != tx0 || err_code !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout: err=%0d ok=%0d tx=%0d code=%0d, required 1/0/0 code=1",
               cnt_err - err0, cnt_ok - ok0, cnt_tx - tx0, err_code);
    end
    // A frame with slow but in-budget byte spacing still goes through.
    f = make_valid(8'h00, 8'd0, {1'b0, 7'($urandom)}, 8'd0);
    send_frame(f, TO / 3);
    idle(3);
    exp_w1 = 7'd0; exp_w2 = f[4][6:0]; exp_gap = 7'd0;
    n_checks++;
    if (cnt_ok - ok0 != 1 || cnt_err - err0 != 1 || cnt_fire != cnt_fire || err_code !== 2'b00 ||
        {pulse_width1, pulse_width2, pulse_gap} !== {exp_w1, exp_w2, exp_gap}) begin
      n_fail++;
      $display("FAIL slow_frame: ok=%0d code=%0d params=%0d/%0d/%0d, required ok=1 code=0 %0d/%0d/%0d",
               cnt_ok - ok0, err_code, pulse_width1, pulse_width2, pulse_gap, exp_w1, exp_w2, exp_gap);
    end
  endtask

  task automatic test_back_to_back();
    int ok0 = cnt_ok, tx0 = cnt_tx, fire0 = cnt_fire;
    frame_t a, b;
    a = make_valid(8'h00, {1'b0, 7'($urandom)}, {1'b0, 7'($urandom)}, {1'b0, 7'($urandom)});
    b = make_valid(8'h01, {1'b0, 7'($urandom)}, {1'b0, 7'($urandom)}, {1'b0, 7'($urandom)});
    send_frame(a, 0);
    send_frame(b, 0);
    idle(3);
    exp_w1 = b[3][6:0]; exp_w2 = b[4][6:0]; exp_gap = b[5][6:0];
    n_checks++;
    if (cnt_ok - ok0 != 2 || cnt_tx - tx0 != 2 || cnt_fire - fire0 != 1) begin
      n_fail++;
      $display("FAIL b2b_counts: ok=%0d tx=%0d fire=%0d, required 2/2/1", cnt_ok - ok0, cnt_tx - tx0, cnt_fire - fire0);
    end
    n_checks++;
    if ({pulse_width1, pulse_width2, pulse_gap} !== {exp_w1, exp_w2, exp_gap}) begin
      n_fail++;
      $display("FAIL b2b_params: %0d/%0d/%0d, required %0d/%0d/%0d", pulse_width1, pulse_width2, pulse_gap,
               exp_w1, exp_w2, exp_gap);
    end
  endtask

  task automatic test_reset_midframe();
    int ok0, err0, tx0;
    send_byte(8'h07); send_byte(8'h01); send_byte(8'h00); send_byte(8'h0A);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    exp_w1 = 0; exp_w2 = 0; exp_gap = 0;
    n_checks++;
    if ({pulse_width1, pulse_width2, pulse_gap, fire, frame_ok, frame_err, err_code, tx_data, tx_flag} !== 36'd0) begin
      n_fail++;
      $display("FAIL midframe_reset: w1=%0d w2=%0d gap=%0d code=%0d tx=%h, required all 0",
               pulse_width1, pulse_width2, pulse_gap, err_code, tx_data);
    end
    ok0 = cnt_ok; err0 = cnt_err; tx0 = cnt_tx;
    send_byte(8'h14); send_byte(8'h05); send_byte(8'h00); send_byte(8'h1D);
    idle(TO + 5);
    n_checks++;
    if (cnt_ok != ok0 || cnt_err != err0 || cnt_tx != tx0 || pulse_width1 !== 7'd0) begin
      n_fail++;
      $display("FAIL midframe_tail: ok=%0d err=%0d tx=%0d w1=%0d, required 0/0/0 w1=0",
               cnt_ok - ok0, cnt_err - err0, cnt_tx - tx0, pulse_width1);
    end
  endtask

  initial begin
    test_reset();
    test_frames(40);
    test_garbage();
    test_timeout();
    test_back_to_back();
    test_reset_midframe();
    test_frames(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
